fir_sched: RTL and testbench
============================

# fir_sched

Round-robin scheduler that shares one 16-tap FIR engine between `NCH` sample channels. It accepts one sample at a time from a requesting channel, pulses the engine's `input_ready`, and waits for the engine's `output_ready`. It then captures the filtered result and returns it, tagged with the channel number, through a valid/ready result port. It sits between the per-channel sample sources and the FIR engine, and is the only block that drives the engine's input side.

## Interface
- `NCH`, 4: number of requesting channels (2..8)
- `W`, 16: sample width, signed
- `TIMEOUT`, 32: maximum cycles to wait for engine `output_ready` (used only with the watchdog enabled)
- `ck` in 1: clock; one clock; every register updates on rising `ck`
- `rst` in 1: reset, synchronous, active-high
- `req_valid` in NCH: channel i has a sample pending
- `req_data` in NCH×W: per-channel signed sample
- `req_ready` out NCH: one-hot; the sample of channel i is accepted this cycle
- `eng_in` out W: sample to the engine, registered
- `eng_input_ready` out 1: one-cycle start pulse to the engine
- `eng_chan` out $clog2(NCH): channel tag to the engine's bank select; a single-bank engine ignores it
- `eng_out` in W: engine result, valid the cycle after `eng_output_ready`
- `eng_output_ready` in 1: engine completion pulse
- `res_valid` out 1: result available
- `res_data` out W: filtered sample
- `res_chan` out $clog2(NCH): channel that produced `res_data`
- `res_ready` in 1: consumer accepts the result
- `err` out 1: one-cycle watchdog pulse
- `err_chan` out $clog2(NCH): channel whose job timed out

## Operation
**Reset values:**
- `req_ready`, `eng_input_ready`, `res_valid`, `err` are 0.
- `eng_in`, `res_data` are 0; `eng_chan`, `res_chan`, `err_chan` are 0.
- The last-grant pointer is NCH-1, so channel 0 has first priority.
- State is IDLE.

**States:**
- **IDLE:** if any `req_valid`, grant the first valid channel searching upward from last-grant+1, with wrap. Assert `req_ready[g]` combinationally, latch `req_data[g]` into `eng_in` and g into `eng_chan`, set last-grant to g, then go to ISSUE. If no channel is valid, stay in IDLE.
- **ISSUE:** `eng_input_ready`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** on `eng_output_ready`, go to CAPTURE.
- **CAPTURE:** `res_data`<=`eng_out`, `res_chan`<=`eng_chan`, `res_valid`<=1, then go to DRAIN.
- **DRAIN:** hold `res_valid` and `res_data` stable until `res_valid`&&`res_ready`. On that cycle, `res_valid` drops at the next edge and the state returns to IDLE.

**Rules:**
- At most one job is outstanding in the engine.
- `req_ready` is zero in every state except IDLE.
- A channel whose `req_valid` drops before grant is skipped without penalty.
- Fairness: with all channels continuously valid, grants cycle 0,1,…,NCH-1,0.
- `eng_output_ready` outside WAIT is ignored.
- `rst` mid-job: the job is discarded, no result or `err` is produced, and all outputs return to their reset values the next cycle.

## Timing
- Acceptance (IDLE, cycle 0) → `eng_input_ready` in cycle 1.
- With the 16-tap engine, `eng_output_ready` arrives in cycle 19 and `eng_out` is valid in cycle 20 (CAPTURE). `res_valid` is therefore high from cycle 21.
- With `res_ready` tied to 1, `res_valid` is high for one cycle and the next grant occurs in cycle 22. Throughput is one sample per 22 cycles.
- Result latency from `eng_output_ready` to `res_valid` is fixed at 2 cycles, independent of the engine's tap count.

## Configuration
- **`FIR_SCHED_WATCHDOG_EN` defined:**
  - A `$clog2(TIMEOUT+1)`-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without `eng_output_ready`, `err` pulses for one cycle, `err_chan`<=`eng_chan`, no result is produced, and the state returns to IDLE.
  - If `eng_output_ready` arrives on the same cycle, completion wins and `err` stays 0.
- **Undefined:** WAIT has no bound, `err` is tied to 0, `err_chan` is tied to 0, and the `TIMEOUT` parameter is unused.

## Structure
- **Package `fir_pkg`:**
  - `sample_t` (signed [15:0])
  - state enum `sched_state_t` {IDLE, ISSUE, WAIT, CAPTURE, DRAIN}
  - default `NCH` and `TIMEOUT` constants
- **Sub-module `rr_arbiter`:** parameterised by NCH. Inputs are the request vector, the last-grant pointer and an enable; outputs are a one-hot grant and its index. It is purely combinational. The pointer register stays in `fir_sched`.

## Test plan
- **Single job:** reset, then `req_valid[2]`=1 with `req_data[2]`=0x1000; engine model returns 0x0800. Required: `req_ready[2]` in cycle 0, `eng_input_ready` in cycle 1 only, `res_valid` in cycle 21 with `res_data`=0x0800 and `res_chan`=2.
- **Round robin:** all four channels held valid with `res_ready`=1. Required: grant order 0,1,2,3,0,1 and no `req_ready` outside IDLE.
- **Back-pressure:** `res_ready`=0 for 10 cycles after `res_valid`. Required: `res_data` stable, no new `req_ready`, then resume one cycle after the handshake.
- **Reset mid-WAIT:** assert `rst` 5 cycles after `eng_input_ready`. Required: IDLE next cycle, no `res_valid`, late `eng_output_ready` ignored, next grant is channel 0.
- **Watchdog** (`FIR_SCHED_WATCHDOG_EN` defined, TIMEOUT=32): engine never completes on channel 1. Required: `err` is a one-cycle pulse 32 cycles after WAIT entry, `err_chan`=1, followed by a grant to channel 2.
- **Watchdog boundary:** `eng_output_ready` arrives on the final timeout cycle. Required: `err`=0 and the result is delivered normally.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and defaults for the fir_sched round-robin FIR engine scheduler.
package fir_pkg;

  localparam int NCH_DEF     = 4;
  localparam int W_DEF       = 16;
  localparam int TIMEOUT_DEF = 32;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DRAIN
  } sched_state_t;

  // Channel-index width; never narrower than one bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_sched_if.sv
// Bundle of the request, engine and result ports of fir_sched.
interface fir_sched_if
  import fir_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF
);
  localparam int IW = chan_w(NCH);

  // Handshakes: a request/result transfers on a cycle where valid && ready;
  // valid never waits on ready, and the result holds data stable while blocked.
  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0][W-1:0] req_data;
  logic [NCH-1:0]        req_ready;

  logic signed [W-1:0]   eng_in;
  logic                  eng_input_ready;
  logic [IW-1:0]         eng_chan;
  logic signed [W-1:0]   eng_out;
  logic                  eng_output_ready;

  logic                  res_valid;
  logic signed [W-1:0]   res_data;
  logic [IW-1:0]         res_chan;
  logic                  res_ready;

  logic                  err;
  logic [IW-1:0]         err_chan;

  modport master (
    input  req_valid, req_data,
    output req_ready,
    output eng_in, eng_input_ready, eng_chan,
    input  eng_out, eng_output_ready,
    output res_valid, res_data, res_chan,
    input  res_ready,
    output err, err_chan
  );

  modport slave (
    output req_valid, req_data,
    input  req_ready,
    input  eng_in, eng_input_ready, eng_chan,
    output eng_out, eng_output_ready,
    input  res_valid, res_data, res_chan,
    output res_ready,
    input  err, err_chan
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request above the last grant, with wrap.
module rr_arbiter
  import fir_pkg::*;
#(
  parameter  int NCH = NCH_DEF,
  localparam int IW  = chan_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last,
  input  logic           en,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gnt_idx,
  output logic           gnt_any
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = last;
    for (int i = 0; i < NCH; i++) begin
      cand = (cand == IW'(NCH - 1)) ? '0 : cand + IW'(1);
      if (en && !gnt_any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        gnt_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_sched.sv
// Shares one FIR engine between NCH channels, one job at a time, round robin.
// Optional watchdog on the engine completion: define FIR_SCHED_WATCHDOG_EN.
module fir_sched
  import fir_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         ck,
  input  logic         rst,
  fir_sched_if.master  bus,
  output sched_state_t dbg_state
);

  localparam int IW = chan_w(NCH);

  sched_state_t        state;
  logic [IW-1:0]       last_gnt;
  logic [NCH-1:0]      gnt;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;
  logic                arb_en;

  logic signed [W-1:0] eng_in_q;
  logic                eng_start_q;
  logic [IW-1:0]       eng_chan_q;
  logic                res_valid_q;
  logic signed [W-1:0] res_data_q;
  logic [IW-1:0]       res_chan_q;

  // Grants only while idle and out of reset, so req_ready is never a phantom accept.
  assign arb_en = (state == IDLE) && !rst;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (bus.req_valid),
    .last    (last_gnt),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

`ifdef FIR_SCHED_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;
  logic          wd_expired;
  logic          err_q;
  logic [IW-1:0] err_chan_q;

  assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));
`endif

  always_ff @(posedge ck) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= IW'(NCH - 1);
      eng_in_q    <= '0;
      eng_start_q <= 1'b0;
      eng_chan_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_chan_q  <= '0;
`ifdef FIR_SCHED_WATCHDOG_EN
      wd_cnt      <= '0;
      err_q       <= 1'b0;
      err_chan_q  <= '0;
`endif
    end else begin
      eng_start_q <= 1'b0;
`ifdef FIR_SCHED_WATCHDOG_EN
      err_q       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (gnt_any) begin
            eng_in_q    <= bus.req_data[gnt_idx];
            eng_chan_q  <= gnt_idx;
            last_gnt    <= gnt_idx;
            eng_start_q <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef FIR_SCHED_WATCHDOG_EN
          wd_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (bus.eng_output_ready) begin
            state <= CAPTURE;
          end
`ifdef FIR_SCHED_WATCHDOG_EN
          // Completion on the last permitted cycle still wins over the timeout.
          else if (wd_expired) begin
            err_q      <= 1'b1;
            err_chan_q <= eng_chan_q;
            state      <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
`endif
        end
        CAPTURE: begin
          res_data_q  <= bus.eng_out;
          res_chan_q  <= eng_chan_q;
          res_valid_q <= 1'b1;
          state       <= DRAIN;
        end
        DRAIN: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready       = gnt;
  assign bus.eng_in          = eng_in_q;
  assign bus.eng_input_ready = eng_start_q;
  assign bus.eng_chan        = eng_chan_q;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_data        = res_data_q;
  assign bus.res_chan        = res_chan_q;
  assign dbg_state           = state;

`ifdef FIR_SCHED_WATCHDOG_EN
  assign bus.err      = err_q;
  assign bus.err_chan = err_chan_q;
`else
  assign bus.err      = 1'b0;
  assign bus.err_chan = '0;
`endif

endmodule

// File: tb/tb_fir_sched.sv
// Directed bench for fir_sched with a behavioural engine (result = sample >>> 1).
module tb_fir_sched;
  import fir_pkg::*;

  localparam int NCH     = 4;
  localparam int W       = 16;
  localparam int TIMEOUT = 32;
  localparam int IW      = 2;

  // ---------------- clock / reset ----------------
  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  fir_sched_if #(.NCH(NCH), .W(W)) bus ();
  sched_state_t dbg_state;

  fir_sched #(.NCH(NCH), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .ck        (ck),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // ---------------- engine model ----------------
  int   eng_delay  = 18;
  bit   eng_enable = 1'b1;
  int   eng_cd     = 0;
  bit   eng_next   = 1'b0;
  logic signed [W-1:0] eng_hold;

  initial begin
    bus.eng_output_ready = 1'b0;
    bus.eng_out          = 16'hDEAD;
    eng_hold             = '0;
    forever begin
      tick();
      bus.eng_output_ready = 1'b0;
      bus.eng_out          = 16'hDEAD;
      if (eng_next) begin
        bus.eng_out = eng_hold;
        eng_next    = 1'b0;
      end
      if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0) begin
          bus.eng_output_ready = 1'b1;
          eng_next             = 1'b1;
        end
      end
      if (bus.eng_input_ready && eng_enable) begin
        eng_cd   = eng_delay;
        eng_hold = bus.eng_in >>> 1;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0]  exp_q[$];
  logic [IW-1:0] exp_chan_q[$];
  int gnt_log[$];
  int gnt_cyc[$];
  bit busy    = 1'b0;
  int viol    = 0;
  int err_cnt = 0;

  initial begin
    logic [W-1:0]  d;
    logic [IW-1:0] c;
    forever begin
      @(negedge ck);
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (bus.err) begin
          err_cnt++;
          busy = 1'b0;
        end
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_pending", exp_q.size(), 1);
          end else begin
            d = exp_q.pop_front();
            c = exp_chan_q.pop_front();
            chk("sb_res_data", {16'h0, bus.res_data}, {16'h0, d});
            chk("sb_res_chan", {30'h0, bus.res_chan}, {30'h0, c});
          end
          busy = 1'b0;
        end
        if (bus.req_ready != '0) begin
          if (busy || $countones(bus.req_ready) != 1) viol++;
          for (int i = 0; i < NCH; i++) begin
            if (bus.req_ready[i]) begin
              gnt_log.push_back(i);
              gnt_cyc.push_back(cyc);
            end
          end
          busy = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.res_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Called in an IDLE cycle (cycle 0); checks the cycle-exact job timeline.
  task automatic run_job(input int ch, input logic [W-1:0] din, input logic [W-1:0] dout);
    exp_q.push_back(dout);
    exp_chan_q.push_back(IW'(ch));
    bus.req_valid[ch] = 1'b1;
    bus.req_data[ch]  = din;
    #1;
    chk("c0_req_ready", {28'h0, bus.req_ready}, 32'(1 << ch));
    tick();
    bus.req_valid = '0;
    #1;
    chk("c1_start", {31'h0, bus.eng_input_ready}, 1);
    chk("c1_eng_in", {16'h0, bus.eng_in}, {16'h0, din});
    chk("c1_eng_chan", {30'h0, bus.eng_chan}, ch);
    chk("c1_req_ready", {28'h0, bus.req_ready}, 0);
    tick();
    chk("c2_start", {31'h0, bus.eng_input_ready}, 0);
    repeat (18) tick();
    chk("c20_res_valid", {31'h0, bus.res_valid}, 0);
    tick();
    chk("c21_res_valid", {31'h0, bus.res_valid}, 1);
    chk("c21_res_data", {16'h0, bus.res_data}, {16'h0, dout});
    chk("c21_res_chan", {30'h0, bus.res_chan}, ch);
    tick();
    chk("c22_res_valid", {31'h0, bus.res_valid}, 0);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int           ch;
    logic [W-1:0] din;
    logic [W-1:0] dout;
  } vec_t;

  vec_t vecs[5];
  int   rr_exp[6];

  initial begin
    int rv_seen;

    vecs[0] = '{2, 16'h1000, 16'h0800};
    vecs[1] = '{0, 16'h8000, 16'hC000};
    vecs[2] = '{1, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{2, 16'h7FFF, 16'h3FFF};
    vecs[4] = '{3, 16'h0003, 16'h0001};
    rr_exp  = '{0, 1, 2, 3, 0, 1};

    // reset values
    do_reset();
    chk("rst_req_ready", {28'h0, bus.req_ready}, 0);
    chk("rst_start", {31'h0, bus.eng_input_ready}, 0);
    chk("rst_res_valid", {31'h0, bus.res_valid}, 0);
    chk("rst_err", {31'h0, bus.err}, 0);
    chk("rst_eng_in", {16'h0, bus.eng_in}, 0);
    chk("rst_res_data", {16'h0, bus.res_data}, 0);
    chk("rst_eng_chan", {30'h0, bus.eng_chan}, 0);
    chk("rst_res_chan", {30'h0, bus.res_chan}, 0);
    chk("rst_err_chan", {30'h0, bus.err_chan}, 0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // single jobs from the table
    for (int i = 0; i < 5; i++) run_job(vecs[i].ch, vecs[i].din, vecs[i].dout);

    // round robin, all channels continuously valid
    do_reset();
    gnt_log.delete();
    gnt_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(W'((rr_exp[i] + 1) * 16'h0080));
      exp_chan_q.push_back(IW'(rr_exp[i]));
    end
    for (int c = 0; c < NCH; c++) bus.req_data[c] = W'((c + 1) * 16'h0100);
    bus.req_valid = '1;
    for (int k = 0; k < 400 && gnt_log.size() < 6; k++) tick();
    bus.req_valid = '0;
    chk("rr_grant_count", gnt_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("rr_order", (i < gnt_log.size()) ? gnt_log[i] : 99, rr_exp[i]);
    if (gnt_cyc.size() >= 2) chk("rr_period", gnt_cyc[1] - gnt_cyc[0], 22);
    wait_drain();

    // back-pressure on the result port
    exp_q.push_back(16'h1234);
    exp_chan_q.push_back(IW'(1));
    exp_q.push_back(16'h0008);
    exp_chan_q.push_back(IW'(0));
    bus.req_valid[1] = 1'b1;
    bus.req_data[1]  = 16'h2468;
    tick();
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    repeat (20) tick();
    bus.req_valid[0] = 1'b1;
    bus.req_data[0]  = 16'h0010;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_res_valid", {31'h0, bus.res_valid}, 1);
      chk("bp_res_data", {16'h0, bus.res_data}, 32'h1234);
      chk("bp_req_ready", {28'h0, bus.req_ready}, 0);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    #1;
    chk("bp_resume_grant", {28'h0, bus.req_ready}, 32'h1);
    chk("bp_res_dropped", {31'h0, bus.res_valid}, 0);
    tick();
    bus.req_valid = '0;
    wait_drain();

    // reset in the middle of WAIT
    bus.req_valid[1] = 1'b1;
    bus.req_data[1]  = 16'h0AAA;
    tick();
    bus.req_valid = '0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("mid_rst_res_valid", {31'h0, bus.res_valid}, 0);
    chk("mid_rst_eng_in", {16'h0, bus.eng_in}, 0);
    chk("mid_rst_eng_chan", {30'h0, bus.eng_chan}, 0);
    rv_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.res_valid) rv_seen++;
    end
    chk("mid_rst_no_result", rv_seen, 0);
    exp_q.push_back(16'h0011);
    exp_chan_q.push_back(IW'(0));
    bus.req_valid   = 4'b0101;
    bus.req_data[0] = 16'h0022;
    bus.req_data[2] = 16'h0044;
    #1;
    chk("mid_rst_next_grant", {28'h0, bus.req_ready}, 32'h1);
    tick();
    bus.req_valid = '0;
    wait_drain();

`ifdef FIR_SCHED_WATCHDOG_EN
    // engine never completes for channel 1
    eng_enable       = 1'b0;
    bus.req_valid    = 4'b0010;
    bus.req_data[1]  = 16'h0100;
    #1;
    chk("wd_grant1", {28'h0, bus.req_ready}, 32'h2);
    tick();
    bus.req_valid   = 4'b0101;
    bus.req_data[0] = 16'h0200;
    bus.req_data[2] = 16'h0080;
    exp_q.push_back(16'h0040);
    exp_chan_q.push_back(IW'(2));
    repeat (32) tick();
    #1;
    chk("wd_c33_err", {31'h0, bus.err}, 0);
    tick();
    #1;
    chk("wd_c34_err", {31'h0, bus.err}, 1);
    chk("wd_err_chan", {30'h0, bus.err_chan}, 1);
    chk("wd_next_grant", {28'h0, bus.req_ready}, 32'h4);
    eng_enable = 1'b1;
    tick();
    bus.req_valid = '0;
    chk("wd_c35_err", {31'h0, bus.err}, 0);
    chk("wd_no_result", {31'h0, bus.res_valid}, 0);
    wait_drain();

    // completion on the final timeout cycle wins
    eng_delay = 32;
    exp_q.push_back(16'h0321);
    exp_chan_q.push_back(IW'(3));
    bus.req_valid[3] = 1'b1;
    bus.req_data[3]  = 16'h0642;
    tick();
    bus.req_valid = '0;
    repeat (32) tick();
    #1;
    chk("wdb_c33_err", {31'h0, bus.err}, 0);
    tick();
    chk("wdb_c34_err", {31'h0, bus.err}, 0);
    tick();
    chk("wdb_c35_res_valid", {31'h0, bus.res_valid}, 1);
    chk("wdb_c35_res_data", {16'h0, bus.res_data}, 32'h0321);
    eng_delay = 18;
    wait_drain();
    chk("err_pulses", err_cnt, 1);
`else
    chk("err_pulses", err_cnt, 0);
`endif

    repeat (3) tick();
    chk("req_ready_violations", viol, 0);
    chk("sb_leftover", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: cycle %0d reached, required finish earlier", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "bench timeout");
  end

endmodule
